// File: rtl/sar_logic.sv
// SAR conversion sequencer: sample, one comparator decision per bit, and
// monotonic switching of the two-wire-per-cap DAC control.
module sar_logic #(
  parameter int ADC_BITS      = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                comp_out,
  input  logic                comp_valid,
  output logic                sample,
  output logic                comp_en,
  output logic [ADC_BITS-1:1] dac_data_h,
  output logic [ADC_BITS-1:1] dac_data_l,
  output logic                busy,
  output logic [ADC_BITS-1:0] dout,
  output logic                dout_valid
);

  localparam int IDX_W       = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;
  localparam int CNT_MAX     = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W       = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam int SAMPLE_LOAD = (SAMPLE_CYCLES > 0) ? SAMPLE_CYCLES - 1 : 0;
  localparam int SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  localparam logic [ADC_BITS-1:1] CAP_VCM   = {(ADC_BITS-1){1'b0}};
  localparam logic [ADC_BITS-1:0] CODE_ZERO = {ADC_BITS{1'b0}};
  localparam logic [IDX_W-1:0]    IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_C_FIRE = 3'd2,
    ST_C_WAIT = 3'd3,
    ST_SETTLE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // A decided bit pulls its cap away from vcm, opposite to the comparator
  // result; the returned {h,l} pair is always 10 or 01, never 11.
  function automatic logic [1:0] cap_code(input logic bit_v);
    logic [1:0] code_v;
    if (bit_v) begin
      code_v = 2'b01;
    end else begin
      code_v = 2'b10;
    end
    return code_v;
  endfunction

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sample_q, sample_d;
  logic                  comp_en_q, comp_en_d;
  logic [ADC_BITS-1:1]   dac_h_q, dac_h_d;
  logic [ADC_BITS-1:1]   dac_l_q, dac_l_d;
  logic                  busy_q, busy_d;
  logic [ADC_BITS-1:0]   result_q, result_d;
  logic [ADC_BITS-1:0]   dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;

  logic                  cnt_zero_s;
  logic                  idx_zero_s;

  assign cnt_zero_s = (cnt_q == CNT_ZERO);
  assign idx_zero_s = (idx_q == IDX_ZERO);

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= IDX_ZERO;
      cnt_q        <= CNT_ZERO;
      sample_q     <= 1'b0;
      comp_en_q    <= 1'b0;
      dac_h_q      <= CAP_VCM;
      dac_l_q      <= CAP_VCM;
      busy_q       <= 1'b0;
      result_q     <= CODE_ZERO;
      dout_q       <= CODE_ZERO;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      sample_q     <= sample_d;
      comp_en_q    <= comp_en_d;
      dac_h_q      <= dac_h_d;
      dac_l_q      <= dac_l_d;
      busy_q       <= busy_d;
      result_q     <= result_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Next-state, bit index and cycle counter sequencing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SAMPLE;
          idx_d   = IDX_W'(ADC_BITS - 1);
          cnt_d   = CNT_W'(SAMPLE_LOAD);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        if (cnt_zero_s) begin
          state_d = ST_C_FIRE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_C_FIRE: begin
        state_d = ST_C_WAIT;
      end
      ST_C_WAIT: begin
        if (comp_valid) begin
          if (idx_zero_s) begin
            state_d = ST_DONE;
          end else if (SETTLE_CYCLES > 0) begin
            idx_d   = idx_q - IDX_W'(1);
            cnt_d   = CNT_W'(SETTLE_LOAD);
            state_d = ST_SETTLE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = ST_C_FIRE;
          end
        end else begin
          state_d = ST_C_WAIT;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero_s) begin
          state_d = ST_C_FIRE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = IDX_ZERO;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output and datapath values loaded on the same edge as the state change.
  always_comb begin
    sample_d     = sample_q;
    comp_en_d    = 1'b0;
    dac_h_d      = dac_h_q;
    dac_l_d      = dac_l_q;
    busy_d       = busy_q;
    result_d     = result_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d   = 1'b1;
          sample_d = 1'b1;
          dac_h_d  = CAP_VCM;
          dac_l_d  = CAP_VCM;
          result_d = CODE_ZERO;
        end else begin
          sample_d = 1'b0;
        end
      end
      ST_SAMPLE: begin
        if (cnt_zero_s) begin
          sample_d  = 1'b0;
          comp_en_d = 1'b1;
        end else begin
          sample_d = 1'b1;
        end
      end
      ST_C_FIRE: begin
        comp_en_d = 1'b0;
      end
      ST_C_WAIT: begin
        if (comp_valid) begin
          for (int k = 0; k < ADC_BITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
              result_d[k] = comp_out;
            end else begin
              result_d[k] = result_q[k];
            end
          end
          for (int k = 1; k < ADC_BITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
              {dac_h_d[k], dac_l_d[k]} = cap_code(comp_out);
            end else begin
              {dac_h_d[k], dac_l_d[k]} = {dac_h_q[k], dac_l_q[k]};
            end
          end
          if (!idx_zero_s && (SETTLE_CYCLES == 0)) begin
            comp_en_d = 1'b1;
          end else begin
            comp_en_d = 1'b0;
          end
        end else begin
          comp_en_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero_s) begin
          comp_en_d = 1'b1;
        end else begin
          comp_en_d = 1'b0;
        end
      end
      ST_DONE: begin
        dout_d       = result_q;
        dout_valid_d = 1'b1;
        busy_d       = 1'b0;
      end
      default: begin
        sample_d = 1'b0;
        busy_d   = 1'b0;
        dac_h_d  = CAP_VCM;
        dac_l_d  = CAP_VCM;
      end
    endcase
  end

  assign sample     = sample_q;
  assign comp_en    = comp_en_q;
  assign dac_data_h = dac_h_q;
  assign dac_data_l = dac_l_q;
  assign busy       = busy_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
